// File: rtl/ntt_wrap_ctrl.sv
// NTT wrapper: owns the N x DW coefficient buffer, multi-lane host load, start/mode handshake
// to an external butterfly core, and in-order valid-qualified unload. Option: BITREV_OUT_EN.
module ntt_wrap_ctrl #(
  parameter int LOG_N = 8,
  parameter int DW    = 16,
  parameter int LANES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   mode,
  input  logic                   we,
  input  logic [LANES*LOG_N-1:0] addr_in,
  input  logic [LANES*DW-1:0]    data_in,
  output logic [LANES*DW-1:0]    data_out,
  output logic                   out_valid,
  output logic                   init_done,
  output logic                   in_done,
  output logic                   cal_done,
  output logic                   done,
  output logic                   err,
  output logic                   core_start,
  output logic                   core_mode,
  input  logic                   core_done,
  input  logic [LANES*LOG_N-1:0] core_addr,
  input  logic [LANES-1:0]       core_we,
  input  logic [LANES*DW-1:0]    core_wdata,
  output logic [LANES*DW-1:0]    core_rdata
);
  localparam int N = 1 << LOG_N;
  localparam logic [LOG_N-1:0] STEP = LOG_N'(LANES);
  localparam logic [LOG_N-1:0] LAST = LOG_N'(N - LANES);

  typedef enum logic [2:0] {S_INIT, S_IDLE, S_CALC, S_UNLOAD, S_DONE} state_t;

  function automatic logic [LOG_N-1:0] rd_map(input logic [LOG_N-1:0] a);
    logic [LOG_N-1:0] r;
`ifdef BITREV_OUT_EN
    for (int i = 0; i < LOG_N; i++) r[i] = a[LOG_N-1-i];
`else
    r = a;
`endif
    return r;
  endfunction

  logic [DW-1:0] mem_q [N];

  state_t                        state_q, state_d;
  logic [LOG_N-1:0]              cnt_q, cnt_d;
  logic [N-1:0]                  wr_map_q, wr_map_d;
  logic                          start_q;
  logic                          in_done_q, in_done_d, init_done_q, init_done_d;
  logic                          cal_done_q, cal_done_d, done_q, done_d, err_q, err_d;
  logic                          core_start_q, core_start_d, core_mode_q, core_mode_d;
  logic                          drain_q, drain_d, rvld_q, rvld_d, rlast_q, rlast_d;
  logic                          out_valid_q, out_valid_d;
  logic [LANES-1:0][LOG_N-1:0]   raddr_q, raddr_d;
  logic [LANES*DW-1:0]           data_out_q, data_out_d, core_rdata_q, core_rdata_d;
  logic [LANES-1:0]              wen;
  logic [LANES-1:0][LOG_N-1:0]   waddr;
  logic [LANES-1:0][DW-1:0]      wdata;
  logic                          start_edge, host_wr, iss_vld;

  assign start_edge = start & ~start_q;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    wr_map_d     = wr_map_q;
    init_done_d  = init_done_q;
    cal_done_d   = cal_done_q;
    done_d       = done_q;
    err_d        = err_q;
    core_start_d = 1'b0;
    core_mode_d  = core_mode_q;
    drain_d      = drain_q;
    iss_vld      = 1'b0;
    host_wr      = 1'b0;
    wen          = '0;
    waddr        = '0;
    wdata        = '0;
    case (state_q)
      S_INIT: begin
        wen = '1;
        for (int k = 0; k < LANES; k++) waddr[k] = cnt_q + LOG_N'(k);
        cnt_d = cnt_q + STEP;
        if (start_edge) err_d = 1'b1;
        if (cnt_q == LAST) begin
          init_done_d = 1'b1;
          state_d     = S_IDLE;
        end
      end
      S_IDLE: begin
        if (start_edge && in_done_q) begin
          core_mode_d  = mode;
          core_start_d = 1'b1;
          state_d      = S_CALC;
        end else begin
          if (start_edge) err_d = 1'b1;
          host_wr = we;
        end
      end
      S_CALC: begin
        wen = core_we;
        for (int k = 0; k < LANES; k++) begin
          waddr[k] = core_addr[k*LOG_N +: LOG_N];
          wdata[k] = core_wdata[k*DW +: DW];
        end
        if (we || start_edge) err_d = 1'b1;
        if (core_done) begin
          cal_done_d = 1'b1;
          cnt_d      = '0;
          drain_d    = 1'b0;
          state_d    = S_UNLOAD;
        end
      end
      S_UNLOAD: begin
        if (we || start_edge) err_d = 1'b1;
        if (!drain_q) begin
          iss_vld = 1'b1;
          cnt_d   = cnt_q + STEP;
          if (cnt_q == LAST) drain_d = 1'b1;
        end
        if (rvld_q && rlast_q) begin
          done_d  = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (start_edge || we) begin
          done_d     = 1'b0;
          cal_done_d = 1'b0;
          wr_map_d   = '0;
          cnt_d      = '0;
          host_wr    = we;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_INIT;
    endcase
    // Ascending lane order: on an address collision the higher lane's write lands last.
    if (host_wr) begin
      wen = '1;
      for (int k = 0; k < LANES; k++) begin
        waddr[k] = addr_in[k*LOG_N +: LOG_N];
        wdata[k] = data_in[k*DW +: DW];
        wr_map_d[addr_in[k*LOG_N +: LOG_N]] = 1'b1;
      end
    end
    in_done_d = &wr_map_d;
  end

  // Unload is two stages: issue address, then registered buffer read.
  always_comb begin
    raddr_d      = raddr_q;
    rvld_d       = iss_vld;
    rlast_d      = iss_vld && (cnt_q == LAST);
    out_valid_d  = rvld_q;
    data_out_d   = data_out_q;
    core_rdata_d = core_rdata_q;
    if (iss_vld)
      for (int k = 0; k < LANES; k++) raddr_d[k] = rd_map(cnt_q + LOG_N'(k));
    if (rvld_q)
      for (int k = 0; k < LANES; k++) data_out_d[k*DW +: DW] = mem_q[raddr_q[k]];
    if (state_q == S_CALC)
      for (int k = 0; k < LANES; k++)
        core_rdata_d[k*DW +: DW] = mem_q[core_addr[k*LOG_N +: LOG_N]];
  end

  always_ff @(posedge clk) begin
    if (!rst)
      for (int k = 0; k < LANES; k++)
        if (wen[k]) mem_q[waddr[k]] <= wdata[k];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_INIT;
      cnt_q        <= '0;
      wr_map_q     <= '0;
      start_q      <= 1'b0;
      in_done_q    <= 1'b0;
      init_done_q  <= 1'b0;
      cal_done_q   <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      core_start_q <= 1'b0;
      core_mode_q  <= 1'b0;
      drain_q      <= 1'b0;
      rvld_q       <= 1'b0;
      rlast_q      <= 1'b0;
      raddr_q      <= '0;
      out_valid_q  <= 1'b0;
      data_out_q   <= '0;
      core_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      wr_map_q     <= wr_map_d;
      start_q      <= start;
      in_done_q    <= in_done_d;
      init_done_q  <= init_done_d;
      cal_done_q   <= cal_done_d;
      done_q       <= done_d;
      err_q        <= err_d;
      core_start_q <= core_start_d;
      core_mode_q  <= core_mode_d;
      drain_q      <= drain_d;
      rvld_q       <= rvld_d;
      rlast_q      <= rlast_d;
      raddr_q      <= raddr_d;
      out_valid_q  <= out_valid_d;
      data_out_q   <= data_out_d;
      core_rdata_q <= core_rdata_d;
    end
  end

  assign data_out   = data_out_q;
  assign out_valid  = out_valid_q;
  assign init_done  = init_done_q;
  assign in_done    = in_done_q;
  assign cal_done   = cal_done_q;
  assign done       = done_q;
  assign err        = err_q;
  assign core_start = core_start_q;
  assign core_mode  = core_mode_q;
  assign core_rdata = core_rdata_q;
endmodule
